// File: rtl/dkong_watch_pkg.sv
// rtl/dkong_watch_pkg.sv - compare-mode constants and predicate for the data watch channels
package dkong_watch_pkg;

   localparam logic [1:0] WM_RANGE = 2'd0;
   localparam logic [1:0] WM_EQ    = 2'd1;
   localparam logic [1:0] WM_NE    = 2'd2;
   localparam logic [1:0] WM_MASK  = 2'd3;

   // Widest data bus the predicate accepts; callers zero-extend into this width.
   localparam int WATCH_DW_MAX = 32;

   // Evaluate one channel predicate on a written byte/word (all operands unsigned).
   // RANGE with lo > hi can never satisfy both bounds, so it naturally yields 0.
   function automatic logic watch_cmp(input logic [1:0]              mode,
                                      input logic [WATCH_DW_MAX-1:0] d,
                                      input logic [WATCH_DW_MAX-1:0] lo,
                                      input logic [WATCH_DW_MAX-1:0] hi);
      logic r;
      case (mode)
         WM_RANGE: r = (d >= lo) && (d <= hi);
         WM_EQ:    r = (d == lo);
         WM_NE:    r = (d != lo);
         default:  r = |(d & lo);
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dkong_watch_ch.sv
// rtl/dkong_watch_ch.sv - one watch channel: address match, compare, flag/pulse/counter registers
module dkong_watch_ch
   import dkong_watch_pkg::*;
#(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_qual,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_d,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [DATA_W-1:0] cfg_lo,
   input  logic [DATA_W-1:0] cfg_hi,
   input  logic [1:0]        cfg_mode,
   output logic              dat,
   output logic              chg,
   output logic              hit,
   output logic [CNT_W-1:0]  cnt
);

   logic dat_q, dat_d;
   logic chg_q, chg_d;
   logic hit_q, hit_d;
   logic match;
   logic r;

   // Decide whether this cycle's write belongs to the channel and what the new flag is.
   always_comb begin
      match = wr_qual && (cpu_addr == cfg_addr);
      r     = watch_cmp(cfg_mode, WATCH_DW_MAX'(cpu_d), WATCH_DW_MAX'(cfg_lo), WATCH_DW_MAX'(cfg_hi));
      dat_d = dat_q;
      chg_d = 1'b0;
      hit_d = 1'b0;
      if (match) begin
         dat_d = r;
         hit_d = 1'b1;
         chg_d = (r != dat_q);
      end
   end

   // Flag holds its value between matching writes; pulses clear after one clock.
   always_ff @(posedge clk) begin
      if (rst) begin
         dat_q <= 1'b0;
         chg_q <= 1'b0;
         hit_q <= 1'b0;
      end else begin
         dat_q <= dat_d;
         chg_q <= chg_d;
         hit_q <= hit_d;
      end
   end

   assign dat = dat_q;
   assign chg = chg_q;
   assign hit = hit_q;

`ifdef DATA_WATCH_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count true writes, sticking at all-ones rather than wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (match && r && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
`else
   assign cnt = '0;
`endif

endmodule

// File: rtl/dkong_data_watch_multi.sv
// rtl/dkong_data_watch_multi.sv - multi-channel CPU write monitor; optional counters via DATA_WATCH_CNT_EN
module dkong_data_watch_multi
   import dkong_watch_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int ADDR_W = 15,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic                      I_CLK,
   input  logic                      I_RST,
   input  logic                      I_CPU_MREQn,
   input  logic                      I_CPU_WRn,
   input  logic [ADDR_W-1:0]         I_CPU_ADDR,
   input  logic [DATA_W-1:0]         I_CPU_D,
   input  logic [NUM_CH*ADDR_W-1:0]  I_CFG_ADDR,
   input  logic [NUM_CH*DATA_W-1:0]  I_CFG_LO,
   input  logic [NUM_CH*DATA_W-1:0]  I_CFG_HI,
   input  logic [NUM_CH*2-1:0]       I_CFG_MODE,
   output logic [NUM_CH-1:0]         O_DAT,
   output logic [NUM_CH-1:0]         O_CHG,
   output logic [NUM_CH-1:0]         O_HIT,
   output logic [NUM_CH*CNT_W-1:0]   O_CNT
);

   logic wr_act;
   logic wr_qual;
   logic wr_q, wr_d;

   // Only the first sampled cycle of a write strobe is evaluated, however long it lasts.
   always_comb begin
      wr_act  = ~I_CPU_MREQn & ~I_CPU_WRn;
      wr_qual = wr_act & ~wr_q;
      wr_d    = wr_act;
   end

   // Strobe history; cleared by reset so a strobe still low afterwards counts afresh.
   always_ff @(posedge I_CLK) begin
      if (I_RST) wr_q <= 1'b0;
      else       wr_q <= wr_d;
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      dkong_watch_ch #(
         .ADDR_W (ADDR_W),
         .DATA_W (DATA_W),
         .CNT_W  (CNT_W)
      ) u_ch (
         .clk      (I_CLK),
         .rst      (I_RST),
         .wr_qual  (wr_qual),
         .cpu_addr (I_CPU_ADDR),
         .cpu_d    (I_CPU_D),
         .cfg_addr (I_CFG_ADDR[k*ADDR_W +: ADDR_W]),
         .cfg_lo   (I_CFG_LO[k*DATA_W +: DATA_W]),
         .cfg_hi   (I_CFG_HI[k*DATA_W +: DATA_W]),
         .cfg_mode (I_CFG_MODE[k*2 +: 2]),
         .dat      (O_DAT[k]),
         .chg      (O_CHG[k]),
         .hit      (O_HIT[k]),
         .cnt      (O_CNT[k*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_dkong_data_watch_multi.sv
// tb/tb_dkong_data_watch_multi.sv - scoreboard bench for dkong_data_watch_multi
module tb_dkong_data_watch_multi;

   localparam int NUM_CH = 4;
   localparam int ADDR_W = 15;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 2;
   localparam int CNT_MAX = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     rst = 1'b1;
   logic                     mreqn = 1'b1;
   logic                     wrn = 1'b1;
   logic [ADDR_W-1:0]        addr = '0;
   logic [DATA_W-1:0]        d = '0;
   logic [NUM_CH*ADDR_W-1:0] cfg_addr_bus;
   logic [NUM_CH*DATA_W-1:0] cfg_lo_bus;
   logic [NUM_CH*DATA_W-1:0] cfg_hi_bus;
   logic [NUM_CH*2-1:0]      cfg_mode_bus;
   logic [NUM_CH-1:0]        o_dat, o_chg, o_hit;
   logic [NUM_CH*CNT_W-1:0]  o_cnt;

   logic [ADDR_W-1:0] cfg_addr [NUM_CH];
   logic [DATA_W-1:0] cfg_lo   [NUM_CH];
   logic [DATA_W-1:0] cfg_hi   [NUM_CH];
   logic [1:0]        cfg_mode [NUM_CH];
   logic [ADDR_W-1:0] nxt_addr [NUM_CH];
   logic [DATA_W-1:0] nxt_lo   [NUM_CH];
   logic [DATA_W-1:0] nxt_hi   [NUM_CH];
   logic [1:0]        nxt_mode [NUM_CH];

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         cfg_addr_bus[k*ADDR_W +: ADDR_W] = cfg_addr[k];
         cfg_lo_bus[k*DATA_W +: DATA_W]   = cfg_lo[k];
         cfg_hi_bus[k*DATA_W +: DATA_W]   = cfg_hi[k];
         cfg_mode_bus[k*2 +: 2]           = cfg_mode[k];
      end
   end

   dkong_data_watch_multi #(
      .NUM_CH (NUM_CH), .ADDR_W (ADDR_W), .DATA_W (DATA_W), .CNT_W (CNT_W)
   ) dut (
      .I_CLK       (clk),
      .I_RST       (rst),
      .I_CPU_MREQn (mreqn),
      .I_CPU_WRn   (wrn),
      .I_CPU_ADDR  (addr),
      .I_CPU_D     (d),
      .I_CFG_ADDR  (cfg_addr_bus),
      .I_CFG_LO    (cfg_lo_bus),
      .I_CFG_HI    (cfg_hi_bus),
      .I_CFG_MODE  (cfg_mode_bus),
      .O_DAT       (o_dat),
      .O_CHG       (o_chg),
      .O_HIT       (o_hit),
      .O_CNT       (o_cnt)
   );

   typedef struct packed {
      logic [NUM_CH-1:0]       dat;
      logic [NUM_CH-1:0]       chg;
      logic [NUM_CH-1:0]       hit;
      logic [NUM_CH*CNT_W-1:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: bus-cycle level view of the watched memory writes.
   bit                 m_in_write;
   bit [NUM_CH-1:0]    m_dat;
   int                 m_cnt [NUM_CH];

   function automatic bit predicate(input logic [1:0] mode, input int unsigned v,
                                    input int unsigned lo, input int unsigned hi);
      case (mode)
         2'd0:    return (lo <= hi) && (v >= lo) && (v <= hi);
         2'd1:    return v == lo;
         2'd2:    return v != lo;
         default: return (v & lo) != 0;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive one bus cycle and record what the outputs must show after the next edge.
   task automatic cyc(input bit r, input bit mq, input bit w,
                      input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] dd);
      exp_t e;
      bit   starts_write;
      bit   res;
      @(negedge clk);
      for (int k = 0; k < NUM_CH; k++) begin
         cfg_addr[k] = nxt_addr[k];
         cfg_lo[k]   = nxt_lo[k];
         cfg_hi[k]   = nxt_hi[k];
         cfg_mode[k] = nxt_mode[k];
      end
      rst = r; mreqn = mq; wrn = w; addr = a; d = dd;
      e = '0;
      if (r) begin
         m_in_write = 1'b0;
         m_dat      = '0;
         for (int k = 0; k < NUM_CH; k++) m_cnt[k] = 0;
      end else begin
         starts_write = (!mq && !w) && !m_in_write;
         m_in_write   = !mq && !w;
         for (int k = 0; k < NUM_CH; k++) begin
            if (starts_write && a == cfg_addr[k]) begin
               res      = predicate(cfg_mode[k], dd, cfg_lo[k], cfg_hi[k]);
               e.hit[k] = 1'b1;
               e.chg[k] = (res != m_dat[k]);
               m_dat[k] = res;
               if (res && m_cnt[k] < CNT_MAX) m_cnt[k]++;
            end
         end
      end
      e.dat = m_dat;
`ifdef DATA_WATCH_CNT_EN
      for (int k = 0; k < NUM_CH; k++) e.cnt[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
`endif
      sb.push_back(e);
   endtask

   task automatic set_ch(input int k, input logic [ADDR_W-1:0] a, input logic [1:0] mode,
                         input logic [DATA_W-1:0] lo, input logic [DATA_W-1:0] hi);
      nxt_addr[k] = a; nxt_mode[k] = mode; nxt_lo[k] = lo; nxt_hi[k] = hi;
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] dd, input int len);
      for (int i = 0; i < len; i++) cyc(1'b0, 1'b0, 1'b0, a, dd);
      cyc(1'b0, 1'b1, 1'b1, a, dd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1, '0, '0);
   endtask

   // Monitor: outputs are presented every clock; compare against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("O_DAT", 32'(o_dat), 32'(e.dat));
            chk("O_CHG", 32'(o_chg), 32'(e.chg));
            chk("O_HIT", 32'(o_hit), 32'(e.hit));
            chk("O_CNT", 32'(o_cnt), 32'(e.cnt));
         end
      end
   end

   initial begin
      int len;
      bit mq, w;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] dd;
      for (int k = 0; k < NUM_CH; k++) set_ch(k, 15'h7fff, 2'd1, 8'h00, 8'h00);

      // Reset state
      cyc(1'b1, 1'b1, 1'b1, '0, '0);
      cyc(1'b1, 1'b1, 1'b1, '0, '0);
      idle(1);

      // RANGE hits, leaves and stays out of range
      set_ch(0, 15'h600A, 2'd0, 8'h0B, 8'h0D);
      wr(15'h600A, 8'h0C, 1);
      wr(15'h600A, 8'h0E, 1);
      wr(15'h600A, 8'h0F, 1);
      wr(15'h600A, 8'h0B, 1);
      wr(15'h600A, 8'h0D, 1);

      // Long strobe evaluates once
      set_ch(1, 15'h639E, 2'd2, 8'h00, 8'h00);
      wr(15'h639E, 8'h01, 5);
      wr(15'h639E, 8'h00, 2);

      // Shared address, EQ and MASK
      set_ch(2, 15'h6200, 2'd1, 8'h80, 8'h00);
      set_ch(3, 15'h6200, 2'd3, 8'h80, 8'h00);
      wr(15'h6200, 8'h80, 1);
      wr(15'h6201, 8'h80, 1);
      wr(15'h6200, 8'h7F, 1);

      // Inverted range and a read cycle
      set_ch(0, 15'h600A, 2'd0, 8'h10, 8'h05);
      wr(15'h600A, 8'h07, 1);
      cyc(1'b0, 1'b0, 1'b1, 15'h600A, 8'h07);
      cyc(1'b0, 1'b1, 1'b0, 15'h600A, 8'h07);
      idle(1);

      // Saturating counter, then reset during a strobe that outlasts it
      set_ch(1, 15'h639E, 2'd2, 8'h00, 8'h00);
      for (int i = 0; i < 5; i++) wr(15'h639E, 8'h55, 1);
      cyc(1'b0, 1'b0, 1'b0, 15'h639E, 8'h33);
      cyc(1'b1, 1'b0, 1'b0, 15'h639E, 8'h33);
      cyc(1'b0, 1'b0, 1'b0, 15'h639E, 8'h33);
      cyc(1'b0, 1'b0, 1'b0, 15'h639E, 8'h33);
      idle(2);

      // Randomized traffic with reconfiguration
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) == 0)
            set_ch($urandom_range(0, NUM_CH-1), 15'h6000 + 15'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 8'($urandom_range(0, 20)), 8'($urandom_range(0, 20)));
         if ($urandom_range(0, 49) == 0) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), '0, '0);
         end else begin
            mq  = ($urandom_range(0, 9) < 3);
            w   = ($urandom_range(0, 9) < 4);
            a   = ($urandom_range(0, 7) == 0) ? 15'($urandom) : 15'h6000 + 15'($urandom_range(0, 3));
            dd  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
            len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++) cyc(1'b0, mq, w, a, dd);
         end
      end
      idle(2);

      @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
